systolic_conv_engine: RTL and testbench
=======================================

Name: systolic_conv_engine

Overview:
Parametrised weight-stationary systolic 2-D convolution engine, successor to the fixed 3x3-kernel / 4x4-image array.
- Computes a valid-mode (no padding) convolution of an NxN image with a KxK kernel, giving an MxM result, M = N-K+1.
- Adds start/busy/done handshake, a raster-order result stream, arithmetic right-shift requantisation, and selectable saturate/wrap output.
- Sits between the feature-map buffer and the accumulator/pooling stage of the accelerator datapath.

Parameters:
DW, 8, signed operand and result width (two's complement)
K, 3, kernel edge; K >= 1
N, 4, image edge; N >= K (elaboration error otherwise)
AW, 2*DW+$clog2(K*K), internal accumulator width; must be >= 2*DW+$clog2(K*K) (elaboration error otherwise)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle request; accepted only in IDLE
img_i  in  N*N*DW  image, row-major; element (r,c) at bits [(r*N+c)*DW +: DW]
ker_i  in  K*K*DW  kernel, row-major, same packing
shift_i  in  $clog2(AW)  arithmetic right shift applied to each full-precision sum
sat_en  in  1  1: clamp to signed DW range; 0: keep low DW bits (wrap)
busy  out  1  high from the cycle after an accepted start through the done cycle
out_valid  out  1  one pulse per result pixel
out_data  out  DW  result pixel, qualified by out_valid
out_idx  out  $clog2(M*M) (min 1)  raster index r*M+c of out_data
res_o  out  M*M*DW  all results, row-major packing; holds until the next accepted start
done  out  1  single-cycle pulse after the last pixel

Behaviour:
- Reset (synchronous, rst=1 at a rising edge) values: FSM=IDLE, busy=0, out_valid=0, out_data=0, out_idx=0, res_o=0, done=0.
- Reset mid-operation aborts immediately. No further out_valid or done is produced.
- Inputs img_i, ker_i, shift_i and sat_en are sampled into internal registers in the start cycle (cycle T). Later changes have no effect on the current job.
- start while busy=1 is ignored, with no effect and no queueing.
- Arithmetic for each result pixel:
  - S(r,c) = sum over i,j in 0..K-1 of img(r+i,c+j)*ker(i,j), signed, exact in AW bits.
  - Q = S >>> shift_i (arithmetic shift).
  - sat_en=1: out = min(max(Q, -2^(DW-1)), 2^(DW-1)-1).
  - sat_en=0: out = Q[DW-1:0].
- FSM states and transitions:
  - IDLE: start=1 -> LOAD.
  - LOAD: K cycles. One kernel row per cycle is loaded into the PE columns, row K-1 first. -> FILL.
  - FILL: K cycles. Systolic pipeline fill, no output. -> RUN.
  - RUN: M*M cycles. One pixel per cycle in raster order. -> DONE.
  - DONE: 1 cycle. done=1. -> IDLE.
- Cycle-exact timing, with T = start cycle:
  - busy rises at T+1.
  - Pixel p (p = 0..M*M-1) has out_valid=1 with out_idx=p at cycle T+1+2K+p.
  - res_o slot p is updated in the same cycle as pixel p.
  - done=1 and busy=1 at T+1+2K+M*M.
  - busy=0 from T+2+2K+M*M. A start in that cycle is accepted.
- out_valid=0 outside RUN; out_data and out_idx hold their last values when out_valid=0.
- res_o is not cleared by start. Slots not yet rewritten keep the previous job's values until overwritten.
- Degenerate K=N (M=1): a single pixel, out_idx width 1, always 0.
- Degenerate K=1: a pure per-pixel scale, with the same timing formula.

Test Plan:
- Defaults, img all 1, ker all 1, shift 0, sat 1, start at T -> out_valid at T+7..T+10, idx 0..3, all data 9; done at T+11; busy high for T+1..T+11.
- img(r,c)=4r+c+1, ker 1 at centre (1,1) and 0 elsewhere, shift 0 -> out_data 6,7,10,11 in idx order; res_o equals the same values, packed.
- img all 127, ker all 127 (S=145161): sat 1 -> all 127; sat 0 -> all 9 (145161 mod 256); with shift 10, sat 1 -> all 127, sat 0 -> 141.
- img all -128, ker all -1, sat 1 -> all 127; ker all 1 -> all -128; ker all 1 with shift 4 -> -72.
- start pulsed again at T+3 and T+5 -> ignored, exactly 4 pixels and one done; start at T+12 (first cycle busy=0) -> accepted, new pixels from T+19.
- rst at T+8 (after pixel 0 at T+7) -> from T+9 outputs 0, no done ever; a fresh start after reset -> full correct job.

Source files
------------

// File: rtl/systolic_conv_engine_if.sv
// Job request / result stream bundle for the systolic convolution engine.
// The master side issues jobs; the slave side is the engine.
interface systolic_conv_engine_if #(
    parameter int DW = 8,
    parameter int K  = 3,
    parameter int N  = 4,
    parameter int AW = 2*DW+$clog2(K*K)
);
    localparam int M  = N - K + 1;
    localparam int MM = M * M;
    localparam int IW = (MM > 1) ? $clog2(MM) : 1;
    localparam int SW = $clog2(AW);

    logic              start;
    logic [N*N*DW-1:0] img_i;
    logic [K*K*DW-1:0] ker_i;
    logic [SW-1:0]     shift_i;
    logic              sat_en;
    logic              busy;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_idx;
    logic [MM*DW-1:0]  res_o;
    logic              done;

    modport master (
        output start, img_i, ker_i, shift_i, sat_en,
        input  busy, out_valid, out_data, out_idx, res_o, done
    );

    modport slave (
        input  start, img_i, ker_i, shift_i, sat_en,
        output busy, out_valid, out_data, out_idx, res_o, done
    );
endinterface

// File: rtl/systolic_conv_engine.sv
// Weight-stationary KxK valid-mode convolution over an NxN image.
// Kernel rows shift into the PE array, then one pixel per cycle streams out.
module systolic_conv_engine #(
    parameter int DW = 8,
    parameter int K  = 3,
    parameter int N  = 4,
    parameter int AW = 2*DW+$clog2(K*K)
) (
    input logic             clk,
    input logic             rst,
    systolic_conv_engine_if.slave bus
);
    localparam int M   = N - K + 1;
    localparam int MM  = M * M;
    localparam int IW  = (MM > 1) ? $clog2(MM) : 1;
    localparam int SW  = $clog2(AW);
    localparam int CW  = $clog2(((K > MM) ? K : MM) + 1);
    localparam int PW  = $clog2(MM + 1);
    localparam int RW  = $clog2(M + 1);
    localparam int BW  = $clog2(N*N*DW);
    localparam int KBW = $clog2(K*K*DW);

    localparam logic signed [AW-1:0] MAXV =
        {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV =
        {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    if (N < K) begin : g_chk_n
        $error("systolic_conv_engine: N must be >= K");
    end
    if (AW < 2*DW+$clog2(K*K)) begin : g_chk_aw
        $error("systolic_conv_engine: AW too narrow");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [N*N*DW-1:0]    img_q, img_d;
    logic [K*K*DW-1:0]    ker_q, ker_d;
    logic [SW-1:0]        shift_q, shift_d;
    logic                 sat_q, sat_d;
    logic signed [DW-1:0] w_q [K][K];
    logic signed [DW-1:0] w_d [K][K];
    logic [RW-1:0]        row_q, row_d;
    logic [RW-1:0]        col_q, col_d;
    logic [PW-1:0]        px_q, px_d;
    logic [DW-1:0]        dat_q, dat_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [MM*DW-1:0]     res_q, res_d;

    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] qv;
    logic [BW-1:0]        base;
    logic [KBW-1:0]       kbase;
    logic [DW-1:0]        pix;
    logic                 emit;

    // Window MAC for the pixel at (row_q, col_q) against the stationary weights
    always_comb begin
        sum  = '0;
        base = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                base = BW'(((int'(row_q) + i) * N + int'(col_q) + j) * DW);
                sum  = sum + AW'(signed'(img_q[base +: DW])) * AW'(w_q[i][j]);
            end
        end
        qv  = sum >>> shift_q;
        pix = qv[DW-1:0];
        if (sat_q && (qv > MAXV)) begin
            pix = MAXV[DW-1:0];
        end else if (sat_q && (qv < MINV)) begin
            pix = MINV[DW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        img_d   = img_q;
        ker_d   = ker_q;
        shift_d = shift_q;
        sat_d   = sat_q;
        w_d     = w_q;
        row_d   = row_q;
        col_d   = col_q;
        px_d    = px_q;
        dat_d   = dat_q;
        idx_d   = idx_q;
        res_d   = res_q;
        kbase   = '0;
        emit    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    img_d   = bus.img_i;
                    ker_d   = bus.ker_i;
                    shift_d = bus.shift_i;
                    sat_d   = bus.sat_en;
                    row_d   = '0;
                    col_d   = '0;
                    px_d    = '0;
                end
            end
            S_LOAD: begin
                for (int i = 1; i < K; i++) begin
                    w_d[i] = w_q[i-1];
                end
                for (int j = 0; j < K; j++) begin
                    kbase     = KBW'(((K - 1 - int'(cnt_q)) * K + j) * DW);
                    w_d[0][j] = ker_q[kbase +: DW];
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(K - 1)) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                end
            end
            S_FILL: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(K - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    emit    = 1'b1;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MM - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    emit = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results are registered one cycle ahead of the RUN slot they show in
        if (emit) begin
            dat_d = pix;
            idx_d = IW'(px_q);
            for (int s = 0; s < MM; s++) begin
                if (px_q == PW'(s)) begin
                    res_d[s*DW +: DW] = pix;
                end
            end
            px_d = px_q + PW'(1);
            if (col_q == RW'(M - 1)) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            img_q   <= '0;
            ker_q   <= '0;
            shift_q <= '0;
            sat_q   <= 1'b0;
            w_q     <= '{default: '0};
            row_q   <= '0;
            col_q   <= '0;
            px_q    <= '0;
            dat_q   <= '0;
            idx_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            img_q   <= img_d;
            ker_q   <= ker_d;
            shift_q <= shift_d;
            sat_q   <= sat_d;
            w_q     <= w_d;
            row_q   <= row_d;
            col_q   <= col_d;
            px_q    <= px_d;
            dat_q   <= dat_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.out_data  = dat_q;
    assign bus.out_idx   = idx_q;
    assign bus.res_o     = res_q;
endmodule

// File: tb/tb_systolic_conv_engine.sv
// Scoreboard bench for systolic_conv_engine against an arithmetic model.
// Jobs push expected pixels; a negedge monitor pops and compares them.
module tb_systolic_conv_engine;
    localparam int DW = 8;
    localparam int K  = 3;
    localparam int N  = 4;
    localparam int M  = N - K + 1;
    localparam int MM = M * M;
    localparam int AW = 2*DW+$clog2(K*K);
    localparam int SW = $clog2(AW);

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t             exp_q[$];
    int               done_q[$];
    logic [MM*DW-1:0] exp_res = '0;
    int               img_m[N*N];
    int               ker_m[K*K];
    exp_t             e;
    int               dc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_conv_engine_if #(.DW(DW), .K(K), .N(N)) bus ();

    systolic_conv_engine #(.DW(DW), .K(K), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Plain valid-mode convolution, shift and clamp/wrap in int arithmetic
    function automatic logic [DW-1:0] ref_pix(int r, int c, int sh, bit sat);
        int s;
        int q;
        s = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += img_m[(r+i)*N + c + j] * ker_m[i*K + j];
        q = s >>> sh;
        if (sat) begin
            if (q > (2**(DW-1) - 1)) q = 2**(DW-1) - 1;
            if (q < -(2**(DW-1))) q = -(2**(DW-1));
        end
        return q[DW-1:0];
    endfunction

    task automatic fill(input int iv, input int kv);
        foreach (img_m[i]) img_m[i] = iv;
        foreach (ker_m[i]) ker_m[i] = kv;
    endtask

    task automatic fill_rand();
        foreach (img_m[i]) img_m[i] = int'($urandom_range(0, 255)) - 128;
        foreach (ker_m[i]) ker_m[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic wait_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Raises start in the current cycle, then scrambles the inputs
    task automatic issue(input int sh, input bit sat, output int t);
        logic [DW-1:0] d;
        t = cyc;
        bus.start = 1'b1;
        foreach (img_m[i]) bus.img_i[i*DW +: DW] = DW'(img_m[i]);
        foreach (ker_m[i]) bus.ker_i[i*DW +: DW] = DW'(ker_m[i]);
        bus.shift_i = SW'(sh);
        bus.sat_en  = sat;
        for (int p = 0; p < MM; p++) begin
            d = ref_pix(p / M, p % M, sh, sat);
            exp_res[p*DW +: DW] = d;
            exp_q.push_back('{p, d, t + 1 + 2*K + p});
        end
        done_q.push_back(t + 1 + 2*K + MM);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        foreach (img_m[i]) bus.img_i[i*DW +: DW] = DW'($urandom);
        foreach (ker_m[i]) bus.ker_i[i*DW +: DW] = DW'($urandom);
        bus.shift_i = SW'($urandom);
        bus.sat_en  = ~sat;
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            #1;
            if (!bus.busy && exp_q.size() == 0 && done_q.size() == 0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending pixels, expected 0", nm, exp_q.size());
            exp_q.delete();
            done_q.delete();
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_valid"}, bus.out_valid, 0);
        chk({nm, "_data"}, bus.out_data, 0);
        chk({nm, "_idx"}, bus.out_idx, 0);
        chk({nm, "_res"}, bus.res_o, 0);
        chk({nm, "_done"}, bus.done, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_pixel: got idx %0d, expected no pixel (cycle %0d)",
                             bus.out_idx, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_idx", bus.out_idx, e.idx);
                    chk("pix_data", bus.out_data, e.data);
                    chk("pix_cycle", cyc, e.cyc);
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    dc = done_q.pop_front();
                    chk("done_cycle", cyc, dc);
                    chk("done_busy", bus.busy, 1);
                    for (int s = 0; s < MM; s++)
                        chk("res_slot", bus.res_o[s*DW +: DW], exp_res[s*DW +: DW]);
                end
            end
        end
    end

    initial begin
        int t;
        int t2;
        int tbl[7][4] = '{
            '{127, 127, 0, 1}, '{127, 127, 0, 0},
            '{127, 127, 10, 1}, '{127, 127, 10, 0},
            '{-128, -1, 0, 1}, '{-128, 1, 0, 1},
            '{-128, 1, 4, 1}
        };
        bus.start   = 1'b0;
        bus.img_i   = '0;
        bus.ker_i   = '0;
        bus.shift_i = '0;
        bus.sat_en  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // All-ones job with timing probes and ignored restarts
        fill(1, 1);
        chk("busy_idle", bus.busy, 0);
        issue(0, 1'b1, t);
        wait_neg(t + 1);
        chk("busy_rise", bus.busy, 1);
        wait_neg(t + 3);
        pulse_start();
        wait_neg(t + 5);
        pulse_start();
        wait_neg(t + 11);
        chk("busy_last", bus.busy, 1);
        wait_neg(t + 12);
        chk("busy_fall", bus.busy, 0);

        // Centre-tap kernel issued in the first idle cycle
        foreach (img_m[i]) img_m[i] = i + 1;
        foreach (ker_m[i]) ker_m[i] = (i == (K/2)*K + K/2) ? 1 : 0;
        issue(0, 1'b1, t2);
        wait_neg(t + 19);
        chk("restart_valid", bus.out_valid, 1);
        wait_idle("centre");
        chk("res_hold", bus.res_o, exp_res);

        foreach (tbl[k]) begin
            fill(tbl[k][0], tbl[k][1]);
            issue(tbl[k][2], tbl[k][3] != 0, t);
            wait_idle("corner");
        end

        // Abort after pixel 1
        fill_rand();
        issue(2, 1'b1, t);
        wait_neg(t + 8);
        #1;
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("abort");
        repeat (20) @(negedge clk);
        fill_rand();
        issue(3, 1'b0, t);
        wait_idle("after_abort");

        for (int n = 0; n < 25; n++) begin
            fill_rand();
            issue(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2**SW - 1))
                                             : int'($urandom_range(0, 12)),
                  1'($urandom), t);
            wait_idle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
